// File: rtl/fifo_param.sv
// Register-based synchronous FIFO with first-word-fall-through read, empty bypass and credit output.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_EN.
module fifo_param #(
  parameter int ID            = 0,
  parameter int WIDTH         = 33,
  parameter int DEPTH         = 64,
  parameter int CREDIT_MARGIN = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [WIDTH-1:0]         i_d_in,
  input  logic                     i_enq,
  input  logic                     i_deq,
  output logic [WIDTH-1:0]         o_d_out,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_c_out,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [1:0]               o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_INC    = AW'(1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_CREDIT = CW'(DEPTH - CREDIT_MARGIN);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || CREDIT_MARGIN < 1 ||
      CREDIT_MARGIN >= DEPTH || ID < 0) begin : g_param_error
    $error("fifo_param: illegal parameter set");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_bypass;

  // Occupancy flags and per-cycle push/pop decisions; reset blocks all traffic.
  always_comb begin
    w_empty  = (r_count == {CW{1'b0}});
    w_full   = (r_count == CNT_FULL);
    w_bypass = w_empty & i_enq & i_deq;
    if (i_rst) begin
      w_pop  = 1'b0;
      w_push = 1'b0;
    end else begin
      w_pop  = i_deq & ~w_empty;
      // Empty enq+deq goes through the bypass and never lands in memory.
      w_push = i_enq & ~(w_full & ~i_deq) & ~(w_empty & i_deq);
    end
  end

  // Combinational outputs: fall-through head, bypass data and handshake flags.
  always_comb begin
    o_d_out = w_bypass ? i_d_in : r_mem[r_rd_ptr];
    o_c_out = (r_count <= CNT_CREDIT) & ~w_full;
    o_count = r_count;
    if (i_rst) begin
      o_valid = 1'b0;
      o_busy  = 1'b0;
    end else begin
      o_valid = i_deq & (~w_empty | i_enq);
      o_busy  = i_enq & w_full & ~i_deq;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= {AW{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_INC;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_INC;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_d_in;
    end
  end

`ifdef FIFO_ERR_EN
  logic [1:0] r_err;

  // Sticky overflow (bit 0) and underflow (bit 1) flags, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 2'b00;
    end else begin
      if (i_enq & w_full & ~i_deq) begin
        r_err[0] <= 1'b1;
      end
      if (i_deq & w_empty & ~i_enq) begin
        r_err[1] <= 1'b1;
      end
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 2'b00;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param at DEPTH=4, CREDIT_MARGIN=2.
// Error-flag expectations follow whether FIFO_ERR_EN is defined for the build.
module tb_fifo_param;

  localparam int WIDTH = 33;
  localparam int DEPTH = 4;
  localparam int CM    = 2;

`ifdef FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d_in;
  logic             enq;
  logic             deq;
  logic [WIDTH-1:0] d_out;
  logic             valid;
  logic             busy;
  logic             c_out;
  logic [2:0]       count;
  logic [1:0]       err;

  int n_checks;
  int n_fail;

  fifo_param #(
    .ID(0), .WIDTH(WIDTH), .DEPTH(DEPTH), .CREDIT_MARGIN(CM)
  ) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_d_in (d_in),
    .i_enq  (enq),
    .i_deq  (deq),
    .o_d_out(d_out),
    .o_valid(valid),
    .o_busy (busy),
    .o_c_out(c_out),
    .o_count(count),
    .o_err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a rising edge and let combinational outputs settle.
  task automatic drive(input logic r, input logic e, input logic d, input logic [WIDTH-1:0] v);
    rst  = r;
    enq  = e;
    deq  = d;
    d_in = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_err;
  logic [WIDTH-1:0] drain_exp [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drain_exp[0] = 33'h2;
    drain_exp[1] = 33'h3;
    drain_exp[2] = 33'h4;
    drain_exp[3] = 33'h9;

    drive(1'b1, 1'b0, 1'b0, 33'h0);
    tick();
    tick();

    // Reset values
    drive(1'b0, 1'b0, 1'b0, 33'h0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_c_out", 64'(c_out), 64'd1);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_err",   64'(err),   64'd0);

    // Single enqueue becomes visible at head next cycle
    drive(1'b0, 1'b1, 1'b0, 33'hA);
    tick();
    drive(1'b0, 1'b0, 1'b0, 33'h0);
    check("enq1_count", 64'(count), 64'd1);
    check("enq1_c_out", 64'(c_out), 64'd1);
    check("enq1_d_out", 64'(d_out), 64'hA);
    check("enq1_valid", 64'(valid), 64'd0);

    // Pop it back out
    drive(1'b0, 1'b0, 1'b1, 33'h0);
    check("pop1_valid", 64'(valid), 64'd1);
    check("pop1_d_out", 64'(d_out), 64'hA);
    tick();

    // Empty bypass
    drive(1'b0, 1'b1, 1'b1, 33'h15);
    check("byp_valid", 64'(valid), 64'd1);
    check("byp_d_out", 64'(d_out), 64'h15);
    tick();
    drive(1'b0, 1'b0, 1'b0, 33'h0);
    check("byp_count", 64'(count), 64'd0);

    // Underflow attempt
    drive(1'b0, 1'b0, 1'b1, 33'h0);
    check("unf_valid", 64'(valid), 64'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 33'h0);
    exp_err = {ERR_EN, 1'b0};
    check("unf_count", 64'(count), 64'd0);
    check("unf_err",   64'(err),   64'(exp_err));

    // Fill to full; credit drops from count=3
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, WIDTH'(i));
      check($sformatf("fill%0d_busy", i), 64'(busy), 64'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 33'h0);
      check($sformatf("fill%0d_count", i), 64'(count), 64'(i));
      check($sformatf("fill%0d_c_out", i), 64'(c_out), (i <= 2) ? 64'd1 : 64'd0);
    end

    // Overflow attempt is rejected
    drive(1'b0, 1'b1, 1'b0, 33'h5);
    check("ovf_busy", 64'(busy), 64'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 33'h0);
    exp_err = {ERR_EN, ERR_EN};
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_err",   64'(err),   64'(exp_err));
    check("ovf_head",  64'(d_out), 64'h1);

    // Full FIFO with simultaneous enq/deq
    drive(1'b0, 1'b1, 1'b1, 33'h9);
    check("fed_valid", 64'(valid), 64'd1);
    check("fed_d_out", 64'(d_out), 64'h1);
    check("fed_busy",  64'(busy),  64'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 33'h0);
    check("fed_count", 64'(count), 64'd4);

    // Drain across the pointer wrap
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 33'h0);
      check($sformatf("drn%0d_valid", i), 64'(valid), 64'd1);
      check($sformatf("drn%0d_d_out", i), 64'(d_out), 64'(drain_exp[i]));
      check($sformatf("drn%0d_busy", i), 64'(busy), 64'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 33'h0);
      check($sformatf("drn%0d_count", i), 64'(count), 64'(3 - i));
    end
    check("drn_err_hold", 64'(err), 64'(exp_err));

    // Store 3 words, then reset mid-traffic
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, WIDTH'(33'h20 + i));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 33'h0);
    check("pre_rst_count", 64'(count), 64'd3);
    drive(1'b1, 1'b1, 1'b1, 33'h7);
    check("in_rst_valid", 64'(valid), 64'd0);
    check("in_rst_busy",  64'(busy),  64'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 33'h0);
    check("post_rst_count", 64'(count), 64'd0);
    check("post_rst_c_out", 64'(c_out), 64'd1);
    check("post_rst_valid", 64'(valid), 64'd0);
    check("post_rst_err",   64'(err),   64'd0);
    drive(1'b0, 1'b0, 1'b0, 33'h0);
    tick();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
